// File: rtl/dmi_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_responder_pkg
//  Description : Shared types and constants for the DMI responder. Covers the
//                request opcodes, the response codes, the debug register
//                addresses and the dmcontrol/dmstatus bit positions.
//  Revision    : 1.0  initial release
// ============================================================================
package dmi_responder_pkg;

    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2,
        DMI_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_SUCCESS = 2'd0,
        DMI_FAILED  = 2'd2
    } dmi_resp_e;

    // Register word addresses
    localparam int unsigned ADDR_DATA0     = 32'h04;
    localparam int unsigned ADDR_DMCONTROL = 32'h10;
    localparam int unsigned ADDR_DMSTATUS  = 32'h11;
    localparam int unsigned ADDR_EXIT      = 32'h40;

    // dmcontrol bit positions
    localparam int DMCTRL_DMACTIVE = 0;
    localparam int DMCTRL_NDMRESET = 1;
    localparam int DMCTRL_HALTREQ  = 31;

    // dmstatus fields
    localparam logic [3:0] DMSTATUS_VERSION   = 4'd2;
    localparam int         DMSTATUS_ANYHALTED = 8;
    localparam int         DMSTATUS_ALLHALTED = 9;

endpackage : dmi_responder_pkg
`default_nettype wire

// File: rtl/dmi_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_responder_if
//  Description : DMI request/response channel between a DTM (master) and the
//                debug module responder (slave).
//  Ports       : req  valid/ready + addr/op/data   (master -> slave)
//                resp valid/ready + resp/data      (slave  -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface dmi_responder_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              debug_req_valid;
    logic              debug_req_ready;
    logic [ADDR_W-1:0] debug_req_bits_addr;
    logic [1:0]        debug_req_bits_op;
    logic [DATA_W-1:0] debug_req_bits_data;
    logic              debug_resp_valid;
    logic              debug_resp_ready;
    logic [1:0]        debug_resp_bits_resp;
    logic [DATA_W-1:0] debug_resp_bits_data;

    modport master (
        output debug_req_valid, debug_req_bits_addr, debug_req_bits_op,
               debug_req_bits_data, debug_resp_ready,
        input  debug_req_ready, debug_resp_valid, debug_resp_bits_resp,
               debug_resp_bits_data
    );

    modport slave (
        input  debug_req_valid, debug_req_bits_addr, debug_req_bits_op,
               debug_req_bits_data, debug_resp_ready,
        output debug_req_ready, debug_resp_valid, debug_resp_bits_resp,
               debug_resp_bits_data
    );
endinterface : dmi_responder_if
`default_nettype wire

// File: rtl/dmi_responder_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_responder_regfile
//  Description : Debug register storage and address decode. Read data and the
//                error flag are combinational from the latched request; state
//                changes only on the access strobe.
//  Ports       : clk, reset_n          clock, async active-low reset
//                addr_i/op_i/wdata_i   latched request
//                access_i              perform the access this cycle
//                halted_i              core halted status
//                rdata_o/err_o         access result
//                dmactive_o/ndmreset_o/haltreq_o/exit_o  control outputs
//  Revision    : 1.0  initial release
// ============================================================================
module dmi_responder_regfile
    import dmi_responder_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 2
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic [ADDR_W-1:0] addr_i,
    input  dmi_op_e                op_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    input  wire logic              access_i,
    input  wire logic              halted_i,
    output logic      [DATA_W-1:0] rdata_o,
    output logic                   err_o,
    output logic                   dmactive_o,
    output logic                   ndmreset_o,
    output logic                   haltreq_o,
    output logic      [31:0]       exit_o
);

    logic [DATA_W-1:0] data_q [NUM_DATA];
    logic              dmactive_q;
    logic              ndmreset_q;
    logic              haltreq_q;
    logic [31:0]       exit_q;

    logic                w_data_hit;
    logic [NUM_DATA-1:0] w_data_sel;
    logic [DATA_W-1:0]   w_data_val;
    logic                w_is_ctrl;
    logic                w_is_stat;
    logic                w_is_exit;
    logic                w_mapped;
    logic [DATA_W-1:0]   w_ctrl_word;
    logic [DATA_W-1:0]   w_stat_word;
    logic                w_wr;

    // Only indices below NUM_DATA decode; the rest of 0x04..0x0F is unmapped.
    always_comb begin
        w_data_hit = 1'b0;
        w_data_sel = '0;
        w_data_val = '0;
        for (int i = 0; i < NUM_DATA; i++) begin
            if (addr_i == ADDR_W'(ADDR_DATA0 + i)) begin
                w_data_hit    = 1'b1;
                w_data_sel[i] = 1'b1;
                w_data_val    = data_q[i];
            end
        end
    end

    assign w_is_ctrl = (addr_i == ADDR_W'(ADDR_DMCONTROL));
    assign w_is_stat = (addr_i == ADDR_W'(ADDR_DMSTATUS));
    assign w_is_exit = (addr_i == ADDR_W'(ADDR_EXIT));
    assign w_mapped  = w_data_hit | w_is_ctrl | w_is_stat | w_is_exit;

    always_comb begin
        w_ctrl_word                  = '0;
        w_ctrl_word[DMCTRL_HALTREQ]  = haltreq_q;
        w_ctrl_word[DMCTRL_NDMRESET] = ndmreset_q;
        w_ctrl_word[DMCTRL_DMACTIVE] = dmactive_q;
        w_stat_word                     = '0;
        w_stat_word[3:0]                = DMSTATUS_VERSION;
        w_stat_word[DMSTATUS_ANYHALTED] = halted_i;
        w_stat_word[DMSTATUS_ALLHALTED] = halted_i;
    end

    always_comb begin
        case (op_i)
            DMI_NOP:   err_o = 1'b0;
            DMI_READ:  err_o = ~w_mapped;
            DMI_WRITE: err_o = ~w_mapped | w_is_stat;
            default:   err_o = 1'b1;
        endcase
    end

    // Read data is zero for anything but a successful read.
    always_comb begin
        rdata_o = '0;
        if (op_i == DMI_READ && w_mapped) begin
            if (w_data_hit)     rdata_o = dmactive_q ? w_data_val : '0;
            else if (w_is_ctrl) rdata_o = w_ctrl_word;
            else if (w_is_stat) rdata_o = w_stat_word;
            else                rdata_o = DATA_W'(exit_q);
        end
    end

    assign w_wr = access_i && (op_i == DMI_WRITE) && !err_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DATA; i++) data_q[i] <= '0;
            dmactive_q <= 1'b0;
            ndmreset_q <= 1'b0;
            haltreq_q  <= 1'b0;
            exit_q     <= '0;
        end else if (w_wr) begin
            // Data writes are dropped while the module is inactive.
            if (dmactive_q) begin
                for (int i = 0; i < NUM_DATA; i++) begin
                    if (w_data_sel[i]) data_q[i] <= wdata_i;
                end
            end
            if (w_is_ctrl) begin
                dmactive_q <= wdata_i[DMCTRL_DMACTIVE];
                if (wdata_i[DMCTRL_DMACTIVE]) begin
                    ndmreset_q <= wdata_i[DMCTRL_NDMRESET];
                    haltreq_q  <= wdata_i[DMCTRL_HALTREQ];
                end else begin
                    // Deactivation resets the debug module's own state.
                    ndmreset_q <= 1'b0;
                    haltreq_q  <= 1'b0;
                    for (int i = 0; i < NUM_DATA; i++) data_q[i] <= '0;
                end
            end
            if (w_is_exit) exit_q <= 32'(wdata_i);
        end
    end

    assign dmactive_o = dmactive_q;
    assign ndmreset_o = ndmreset_q;
    assign haltreq_o  = haltreq_q;
    assign exit_o     = exit_q;

endmodule : dmi_responder_regfile
`default_nettype wire

// File: rtl/dmi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_responder
//  Description : DMI target. Accepts one request at a time, spends RESP_LAT
//                cycles in the access phase, then holds the response until the
//                DTM consumes it.
//  Ports       : clk, reset_n     clock, async active-low reset
//                dmi              DMI request/response channel (slave side)
//                halted           core halted status
//                dmactive/ndmreset/haltreq  dmcontrol bits to the core
//                exit             exit code, non-zero ends simulation
//  Revision    : 1.0  initial release
// ============================================================================
module dmi_responder
    import dmi_responder_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 2,
    parameter int RESP_LAT = 1
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    dmi_responder_if.slave    dmi,
    input  wire logic         halted,
    output logic              dmactive,
    output logic              ndmreset,
    output logic              haltreq,
    output logic [31:0]       exit
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int             CNT_W    = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESP_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    dmi_op_e           op_q, op_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    dmi_resp_e         resp_q, resp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              w_req_fire;
    logic              w_access;
    logic [DATA_W-1:0] w_rdata;
    logic              w_err;

    assign w_req_fire = (state_q == S_IDLE) && dmi.debug_req_valid;
    assign w_access   = (state_q == S_ACCESS) && (cnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (dmi.debug_req_valid)  state_d = S_ACCESS;
            S_ACCESS: if (cnt_q == '0)          state_d = S_RESP;
            S_RESP:   if (dmi.debug_resp_ready) state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        dmi.debug_req_ready  = (state_q == S_IDLE);
        dmi.debug_resp_valid = (state_q == S_RESP);
    end

    // Request latch, latency counter and response registers
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        resp_d  = resp_q;
        rdata_d = rdata_q;
        if (w_req_fire) begin
            cnt_d   = CNT_INIT;
            addr_d  = dmi.debug_req_bits_addr;
            op_d    = dmi_op_e'(dmi.debug_req_bits_op);
            wdata_d = dmi.debug_req_bits_data;
        end else if (state_q == S_ACCESS) begin
            if (cnt_q == '0) begin
                resp_d  = w_err ? DMI_FAILED : DMI_SUCCESS;
                rdata_d = w_rdata;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            op_q    <= DMI_NOP;
            wdata_q <= '0;
            resp_q  <= DMI_SUCCESS;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    assign dmi.debug_resp_bits_resp = resp_q;
    assign dmi.debug_resp_bits_data = rdata_q;

    dmi_responder_regfile #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_DATA (NUM_DATA)
    ) u_regfile (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr_i     (addr_q),
        .op_i       (op_q),
        .wdata_i    (wdata_q),
        .access_i   (w_access),
        .halted_i   (halted),
        .rdata_o    (w_rdata),
        .err_o      (w_err),
        .dmactive_o (dmactive),
        .ndmreset_o (ndmreset),
        .haltreq_o  (haltreq),
        .exit_o     (exit)
    );

endmodule : dmi_responder
`default_nettype wire

// File: tb/tb_dmi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmi_responder
//  Description : Self-checking bench for dmi_responder. A driver issues
//                requests and pushes the reference model's expected result
//                into a scoreboard; a monitor pops and compares responses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmi_responder;
    import dmi_responder_pkg::*;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 32;
    localparam int NUM_DATA = 2;
    localparam int RESP_LAT = 3;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        halted  = 1'b0;
    logic        dmactive, ndmreset, haltreq;
    logic [31:0] exit_code;

    dmi_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dmi();

    dmi_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RESP_LAT(RESP_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .dmi(dmi), .halted(halted),
        .dmactive(dmactive), .ndmreset(ndmreset), .haltreq(haltreq), .exit(exit_code)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_data [NUM_DATA];
    logic        m_dmactive, m_ndmreset, m_haltreq;
    logic [31:0] m_exit;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic        dmactive;
        logic        ndmreset;
        logic        haltreq;
        logic [31:0] exit_v;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic model_reset();
        foreach (m_data[i]) m_data[i] = 32'h0;
        m_dmactive = 1'b0; m_ndmreset = 1'b0; m_haltreq = 1'b0; m_exit = 32'h0;
    endtask

    function automatic exp_t model_apply(int addr, int op, logic [31:0] wd);
        exp_t e;
        bit   is_data, mapped;
        is_data = (addr >= 4) && (addr < 4 + NUM_DATA);
        mapped  = is_data || addr == 'h10 || addr == 'h11 || addr == 'h40;
        e.resp = 2'd0; e.data = 32'h0; e.acc_cyc = 0;
        if (op == 3 || (op != 0 && !mapped) || (op == 2 && addr == 'h11)) begin
            e.resp = 2'd2;
        end else if (op == 1) begin
            if (is_data)          e.data = m_dmactive ? m_data[addr-4] : 32'h0;
            else if (addr == 'h10) e.data = {m_haltreq, 29'h0, m_ndmreset, m_dmactive};
            else if (addr == 'h11) e.data = 32'h2 + (halted ? 32'h300 : 32'h0);
            else                   e.data = m_exit;
        end else if (op == 2) begin
            if (is_data) begin
                if (m_dmactive) m_data[addr-4] = wd;
            end else if (addr == 'h10) begin
                m_dmactive = wd[0];
                if (wd[0]) begin
                    m_ndmreset = wd[1]; m_haltreq = wd[31];
                end else begin
                    m_ndmreset = 1'b0; m_haltreq = 1'b0;
                    foreach (m_data[i]) m_data[i] = 32'h0;
                end
            end else begin
                m_exit = wd;
            end
        end
        e.dmactive = m_dmactive; e.ndmreset = m_ndmreset;
        e.haltreq  = m_haltreq;  e.exit_v   = m_exit;
        return e;
    endfunction

    // ---------------- resp_ready driver ----------------
    int rr_mode = 0;   // 0 always ready, 1 random, 2 held low
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       dmi.debug_resp_ready = 1'b1;
            1:       dmi.debug_resp_ready = 1'($urandom_range(0, 1));
            default: dmi.debug_resp_ready = 1'b0;
        endcase
    end

    // ---------------- request driver ----------------
    task automatic issue(input int addr, input int op, input logic [31:0] wd);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        while (!dmi.debug_req_ready && t < 200) begin @(negedge clk); t++; end
        if (!dmi.debug_req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        dmi.debug_req_valid     = 1'b1;
        dmi.debug_req_bits_addr = 7'(addr);
        dmi.debug_req_bits_op   = 2'(op);
        dmi.debug_req_bits_data = wd;
        @(posedge clk);
        e = model_apply(addr, op, wd);
        e.acc_cyc = cyc;
        sb.push_back(e);
        #1;
        // Scramble fields so any late sampling of them shows up.
        dmi.debug_req_valid     = 1'b0;
        dmi.debug_req_bits_addr = 7'($urandom);
        dmi.debug_req_bits_op   = 2'($urandom);
        dmi.debug_req_bits_data = $urandom;
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin @(negedge clk); t++; end
        if (sb.size() != 0) begin
            check("resp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic do_req(input int addr, input int op, input logic [31:0] wd);
        issue(addr, op, wd);
        wait_done();
    endtask

    // ---------------- monitor ----------------
    exp_t        cur;
    logic        pending   = 1'b0;
    logic        chk_ready = 1'b0;
    logic [1:0]  snap_resp;
    logic [31:0] snap_data;

    always @(negedge clk) begin
        if (!reset_n) begin
            pending   = 1'b0;
            chk_ready = 1'b0;
        end else begin
            if (chk_ready) begin
                check("req_ready_after_resp", 32'(dmi.debug_req_ready), 32'd1);
                chk_ready = 1'b0;
            end
            if (dmi.debug_resp_valid) begin
                if (!pending) begin
                    if (sb.size() == 0) begin
                        check("spurious_resp_valid", 32'd1, 32'd0);
                    end else begin
                        cur = sb[0];
                        check("latency", 32'(cyc - cur.acc_cyc), 32'(RESP_LAT + 1));
                        check("dmactive", 32'(dmactive), 32'(cur.dmactive));
                        check("ndmreset", 32'(ndmreset), 32'(cur.ndmreset));
                        check("haltreq",  32'(haltreq),  32'(cur.haltreq));
                        check("exit",     exit_code,     cur.exit_v);
                    end
                    snap_resp = dmi.debug_resp_bits_resp;
                    snap_data = dmi.debug_resp_bits_data;
                end else begin
                    check("resp_stable",      32'(dmi.debug_resp_bits_resp), 32'(snap_resp));
                    check("resp_data_stable", dmi.debug_resp_bits_data, snap_data);
                end
                check("req_ready_in_resp", 32'(dmi.debug_req_ready), 32'd0);
                if (dmi.debug_resp_ready) begin
                    if (sb.size() != 0) begin
                        check("resp_code", 32'(dmi.debug_resp_bits_resp), 32'(cur.resp));
                        check("resp_data", dmi.debug_resp_bits_data, cur.data);
                        void'(sb.pop_front());
                    end
                    chk_ready = 1'b1;
                end
                pending = !dmi.debug_resp_ready;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        dmi.debug_req_valid     = 1'b0;
        dmi.debug_req_bits_addr = '0;
        dmi.debug_req_bits_op   = '0;
        dmi.debug_req_bits_data = '0;
        model_reset();

        // Reset state
        #2 reset_n = 1'b0;
        #20;
        check("rst_req_ready",  32'(dmi.debug_req_ready),  32'd1);
        check("rst_resp_valid", 32'(dmi.debug_resp_valid), 32'd0);
        check("rst_exit",       exit_code,                 32'd0);
        check("rst_dmactive",   32'(dmactive),             32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic data access with the module active
        do_req('h10, 2, 32'h1);
        do_req('h04, 2, 32'hDEADBEEF);
        do_req('h04, 1, 32'h0);
        do_req('h05, 2, 32'h0BADF00D);
        do_req('h05, 1, 32'h0);
        do_req('h06, 1, 32'h0);          // first index past NUM_DATA
        do_req('h00, 0, 32'h0);          // nop

        // Inactive module: data writes ignored, deactivation clears state
        do_req('h10, 2, 32'h0);
        do_req('h04, 2, 32'h1234);
        do_req('h04, 1, 32'h0);
        do_req('h10, 2, 32'h80000001);
        check("haltreq_set", 32'(haltreq), 32'd1);
        do_req('h04, 2, 32'h55AA55AA);
        do_req('h10, 1, 32'h0);
        do_req('h10, 2, 32'h0);
        check("haltreq_clr", 32'(haltreq), 32'd0);
        do_req('h10, 2, 32'h1);
        do_req('h04, 1, 32'h0);

        // Errors
        do_req('h7F, 1, 32'h0);
        do_req('h11, 2, 32'hFFFFFFFF);
        do_req('h11, 1, 32'h0);
        do_req('h04, 3, 32'h0);

        // Backpressure: response held, second request must not be taken
        begin
            int t = 0;
            rr_mode = 2;
            @(posedge clk); #2;
            issue('h10, 1, 32'h0);
            while (!dmi.debug_resp_valid && t < 50) begin @(negedge clk); t++; end
            check("bp_resp_seen", 32'(dmi.debug_resp_valid), 32'd1);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (i == 2) begin
                    dmi.debug_req_valid     = 1'b1;
                    dmi.debug_req_bits_addr = 7'h40;
                    dmi.debug_req_bits_op   = 2'd2;
                    dmi.debug_req_bits_data = 32'hBAD0BAD0;
                end
                check("bp_req_ready_low", 32'(dmi.debug_req_ready), 32'd0);
            end
            dmi.debug_req_valid = 1'b0;
            rr_mode = 0;
            wait_done();
            do_req('h40, 1, 32'h0);      // exit must still be 0
        end

        // Halted status, exit, then async reset mid-access
        halted = 1'b1;
        do_req('h11, 1, 32'h0);
        do_req('h40, 2, 32'h1);
        check("exit_written", exit_code, 32'd1);
        @(negedge clk);
        dmi.debug_req_valid     = 1'b1;
        dmi.debug_req_bits_addr = 7'h40;
        dmi.debug_req_bits_op   = 2'd2;
        dmi.debug_req_bits_data = 32'h77;
        @(posedge clk); #1;
        dmi.debug_req_valid = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("midrst_exit",       exit_code,                 32'd0);
        check("midrst_resp_valid", 32'(dmi.debug_resp_valid), 32'd0);
        check("midrst_req_ready",  32'(dmi.debug_req_ready),  32'd1);
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_resp", 32'(dmi.debug_resp_valid), 32'd0);
        end
        check("midrst_exit_after", exit_code, 32'd0);

        // Randomised traffic with random response backpressure
        rr_mode = 1;
        do_req('h10, 2, 32'h1);
        for (int n = 0; n < 150; n++) begin
            int          a, op;
            logic [31:0] wd;
            halted = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0, 1, 2, 3: a = 4 + int'($urandom_range(0, 3));
                4:          a = 'h10;
                5:          a = 'h11;
                6:          a = 'h40;
                default:    a = int'($urandom_range(0, 127));
            endcase
            op = int'($urandom_range(0, 3));
            wd = $urandom;
            if (a == 'h10 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            do_req(a, op, wd);
        end
        rr_mode = 0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule : tb_dmi_responder
`default_nettype wire
